cordic_linear_unit: RTL and testbench

- Parametrised iterative linear-mode CORDIC arithmetic unit that computes either a fixed-point product (multiply mode) or a quotient (divide mode).
- Operands and result share one signed Q format: WL bits total, FL fractional bits.
- Valid/ready handshakes on both the input and output sides.
- Serves as the shared multiply/divide engine for the fixed-point datapath blocks.

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/cordic_linear_step.sv | 33 +++
 rtl/cordic_linear_unit.sv | 126 ++++++++++++
 tb/tb_cordic_linear_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared encodings and result range reduction for cordic_linear_unit.
// Define CORDIC_SAT_EN to clamp out-of-range results; otherwise they wrap.
package cordic_pkg;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {IDLE, ITER, DONE, HOLD} state_t;

    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] raw, input int wl,
                                                      output logic ovf);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wl - 1));
        ovf = (raw > hi) || (raw < lo);
`ifdef CORDIC_SAT_EN
        return (raw > hi) ? hi : (raw < lo) ? lo : raw;
`else
        return raw;
`endif
    endfunction
endpackage

// File: rtl/cordic_linear_step.sv
// cordic_linear_step: one combinational linear-mode CORDIC iteration.
module cordic_linear_step
    import cordic_pkg::*;
#(
    parameter int WL    = 16,
    parameter int FL    = 14,
    parameter int GUARD = 4,
    parameter int IW    = 5
) (
    input  logic signed [WL+GUARD+1:0] x,
    input  logic signed [WL+GUARD+1:0] y,
    input  logic signed [WL:0]         z,
    input  logic        [IW-1:0]       i,
    input  logic                       mode,
    output logic signed [WL+GUARD+1:0] x_n,
    output logic signed [WL+GUARD+1:0] y_n,
    output logic signed [WL:0]         z_n
);
    localparam int XW = WL + 2 + GUARD;
    localparam int ZW = WL + 1;
    localparam logic signed [ZW-1:0] ONE = ZW'(1 << FL);

    logic d, y_add;

    // y accumulates on +d when multiplying, on -d when dividing; z always moves the other way
    always_comb begin
        d = (mode == MODE_MUL) ? !z[ZW-1] : (y[XW-1] == x[XW-1]);
        y_add = (mode == MODE_MUL) == d;
        x_n = x;
        y_n = y_add ? y + (x >>> i) : y - (x >>> i);
        z_n = y_add ? z - (ONE >>> i) : z + (ONE >>> i);
    end
endmodule

// File: rtl/cordic_linear_unit.sv
// cordic_linear_unit: iterative linear CORDIC multiply/divide engine with valid/ready handshakes.
// CORDIC_SAT_EN selects saturation of out-of-range results instead of wrap; ovf flags both.
module cordic_linear_unit
    import cordic_pkg::*;
#(
    parameter int WL     = 16,
    parameter int FL     = 14,
    parameter int N_ITER = 15,
    parameter int GUARD  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic signed [WL-1:0] in1,
    input  logic signed [WL-1:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] out,
    output logic                 ovf,
    output logic                 div_zero
);
    localparam int XW = WL + 2 + GUARD;
    localparam int ZW = WL + 1;
    localparam int IW = $clog2(N_ITER) + 1;
    localparam logic signed [WL-1:0] MAXV = {1'b0, {(WL-1){1'b1}}};

    state_t state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic mode_q, mode_d, dz_q, dz_d, out_valid_q, out_valid_d;
    logic ovf_q, ovf_d, div_zero_q, div_zero_d, sat_ovf;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_n, y_n, a_ext, b_ext;
    logic signed [ZW-1:0] z_q, z_d, z_n;
    logic signed [WL-1:0] out_q, out_d, sat_val;
    logic signed [63:0] raw;

    cordic_linear_step #(.WL(WL), .FL(FL), .GUARD(GUARD), .IW(IW)) u_step (
        .x(x_q), .y(y_q), .z(z_q), .i(i_q), .mode(mode_q),
        .x_n(x_n), .y_n(y_n), .z_n(z_n)
    );

    assign a_ext = XW'(in1) <<< GUARD;
    assign b_ext = XW'(in2) <<< GUARD;

    always_comb begin
        state_d = state_q;
        i_d = i_q;
        mode_d = mode_q;
        dz_d = dz_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        out_d = out_q;
        ovf_d = ovf_q;
        div_zero_d = div_zero_q;
        out_valid_d = out_valid_q;
        sat_ovf = 1'b0;
        raw = (mode_q == MODE_MUL) ? (64'(y_q) + (64'sd1 <<< (GUARD - 1))) >>> GUARD : 64'(z_q);
        sat_val = WL'(sat_trunc(raw, WL, sat_ovf));
        unique case (state_q)
            IDLE: if (in_valid) begin
                mode_d = mode;
                dz_d = (mode == MODE_DIV) && (in2 == '0);
                x_d = (mode == MODE_DIV) ? b_ext : a_ext;
                y_d = (mode == MODE_DIV) ? a_ext : '0;
                z_d = (mode == MODE_DIV) ? '0 : ZW'(in2);
                i_d = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                i_d = i_q + IW'(1);
                state_d = (i_q == IW'(N_ITER - 1)) ? DONE : ITER;
            end
            // a zero divisor leaves y untouched, so its sign is still the dividend's
            DONE: begin
                out_d = dz_q ? (y_q[XW-1] ? -MAXV : MAXV) : sat_val;
                ovf_d = !dz_q && sat_ovf;
                div_zero_d = dz_q;
                state_d = HOLD;
            end
            HOLD: begin
                out_valid_d = !(out_valid_q && out_ready);
                state_d = (out_valid_q && out_ready) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q <= '0;
            mode_q <= MODE_MUL;
            dz_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            div_zero_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            mode_q <= mode_d;
            dz_q <= dz_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            div_zero_q <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out = out_q;
    assign ovf = ovf_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_cordic_linear_unit.sv
// tb_cordic_linear_unit: scoreboard bench comparing the unit against real-valued arithmetic.
module tb_cordic_linear_unit;
    localparam int WL = 16, FL = 14, N_ITER = 15, GUARD = 4;
    localparam int LAT = N_ITER + 2;
    localparam real ONE_R = 2.0 ** FL;
    localparam real MAXP = 2.0 ** (WL - 1) - 1.0;
    localparam real MINN = -(2.0 ** (WL - 1));
    localparam real SPAN = 2.0 ** WL;

    logic clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 1;
    logic signed [WL-1:0] in1 = '0, in2 = '0;
    logic in_ready, out_valid, ovf, div_zero;
    logic signed [WL-1:0] out;

    typedef struct {real e; int tol; bit ov; bit dz; bit m; int a; int b;} exp_t;
    exp_t sb[$];
    exp_t mx;
    int n_checks = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    bit prev_valid = 0;
    logic signed [WL-1:0] held;

    cordic_linear_unit #(.WL(WL), .FL(FL), .N_ITER(N_ITER), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .ovf(ovf), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input bit m, input int a, input int b);
        exp_t x;
        real r;
        x.m = m; x.a = a; x.b = b; x.dz = 0; x.ov = 0; x.tol = 2;
        if (m && b == 0) begin
            x.dz = 1; x.tol = 0;
            x.e = (a >= 0) ? MAXP : -MAXP;
            return x;
        end
        r = m ? real'(a) * ONE_R / real'(b) : real'(a) * real'(b) / ONE_R;
        x.e = r;
        if (r >= MAXP + 0.5 || r < MINN - 0.5) begin
            x.ov = 1;
`ifdef CORDIC_SAT_EN
            x.e = (r > 0.0) ? MAXP : MINN;
            x.tol = 0;
`else
            x.e = (r > 0.0) ? r - SPAN : r + SPAN;
`endif
        end
        return x;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic issue(input bit m, input int a, input int b);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: in_ready=%0d, expected 1", in_ready);
            return;
        end
        mode = m; in1 = WL'(a); in2 = WL'(b); in_valid = 1;
        sb.push_back(model(m, a, b));
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 200) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (sb.size() != 0 || !in_ready) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d in_ready=%0d, expected 0 and 1", sb.size(), in_ready);
        end
    endtask

    // monitor: latency on each rising out_valid, result on each output handshake
    always @(negedge clk) begin
        if (!rst_n) prev_valid = 0;
        else begin
            if (out_valid && !prev_valid) begin
                n_checks++;
                if (cyc - acc_cyc != LAT) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, expected %0d", cyc - acc_cyc, LAT);
                end
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: out=%0d, expected no output", out);
                end else begin
                    mx = sb.pop_front();
                    n_checks += 3;
                    if (real'(out) - mx.e > real'(mx.tol) || mx.e - real'(out) > real'(mx.tol)) begin
                        n_fail++;
                        $display("FAIL result m=%0d a=%0d b=%0d: out=%0d, expected %0.3f +/- %0d",
                                 mx.m, mx.a, mx.b, out, mx.e, mx.tol);
                    end
                    if (ovf != mx.ov) begin
                        n_fail++;
                        $display("FAIL ovf m=%0d a=%0d b=%0d: got %0d, expected %0d", mx.m, mx.a, mx.b, ovf, mx.ov);
                    end
                    if (div_zero != mx.dz) begin
                        n_fail++;
                        $display("FAIL div_zero m=%0d a=%0d b=%0d: got %0d, expected %0d",
                                 mx.m, mx.a, mx.b, div_zero, mx.dz);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", int'(out), 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_div_zero", div_zero, 0);
        rst_n = 1;
        issue(0, 8192, 12288);
        issue(1, 6144, 12288);
        issue(1, -4096, 16384);
        issue(0, 24576, 24576);
        issue(0, -24576, 24576);
        issue(1, 100, 0);
        issue(1, -100, 0);
        for (int k = 0; k < 25; k++)
            issue(0, int'($urandom_range(0, 16384)) - 8192, int'($urandom_range(0, 65534)) - 32767);
        for (int k = 0; k < 25; k++) begin
            int b, lim;
            b = int'($urandom_range(8192, 32767));
            if ($urandom_range(0, 1) == 1) b = -b;
            lim = ((b < 0 ? -b : b) * 19) / 10;
            if (lim > 32767) lim = 32767;
            issue(1, int'($urandom_range(0, 2 * lim)) - lim, b);
        end
        drain();

        // backpressure: result must hold and a new request must be ignored
        out_ready = 0;
        issue(0, 5000, -7000);
        for (int t = 0; t < 50 && !out_valid; t++) begin @(posedge clk); #1; end
        chk("bp_valid", out_valid, 1);
        held = out;
        in_valid = 1; mode = 1; in1 = 16'sd1234; in2 = 16'sd4321;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_out_stable", int'(out), int'(held));
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid_held", out_valid, 1);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_extra_valid", out_valid, 0);
        chk("bp_no_pending", sb.size(), 0);

        // reset while iterating at i=5
        issue(0, 3000, 9000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        sb.delete();
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", int'(out), 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_div_zero", div_zero, 0);
        @(posedge clk); #1;
        rst_n = 1;
        issue(0, -12000, 10000);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
